// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, completes it after a fixed
// latency with a one-cycle response; stores merge byte lanes into a 64-bit word RAM.

module data_mem_lane (
  input  logic       i_en,
  input  logic [7:0] i_old,
  input  logic [7:0] i_new,
  output logic [7:0] o_byte
);
  assign o_byte = i_en ? i_new : i_old;
endmodule

module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [1:0]  r_size;
  logic [63:0] r_wdata;
  logic [63:0] r_mem [DEPTH];

  logic          w_accept, w_misal, w_oor, w_err, w_commit;
  logic [2:0]    w_off, w_mask;
  logic [7:0]    w_be;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_rdword, w_shdata;
  logic [7:0][7:0] w_old_b, w_new_b, w_merged_b;

  assign w_accept = req_valid & req_ready;
  assign w_off    = r_addr[2:0];
  assign w_idx    = r_addr[AW+2:3];
  assign w_rdword = r_mem[w_idx];

  always_comb begin
    w_mask = 3'b000;
    w_be   = 8'h01 << w_off;
    case (r_size)
      2'b00: begin w_mask = 3'b111; w_be = 8'hFF;            end
      2'b01: begin w_mask = 3'b011; w_be = 8'h0F << w_off;   end
      2'b10: begin w_mask = 3'b001; w_be = 8'h03 << w_off;   end
      default: begin w_mask = 3'b000; w_be = 8'h01 << w_off; end
    endcase
  end

  assign w_misal  = |(w_off & w_mask);
  assign w_oor    = (r_addr[63:3] >= 61'(DEPTH));
  assign w_err    = w_misal | w_oor;
  assign w_commit = (r_state == RESP) & r_write & ~w_err;

  // Store data is LSB-justified; move it up to the byte lane the address selects.
  assign w_shdata = r_wdata << {w_off, 3'b000};
  assign w_old_b  = w_rdword;
  assign w_new_b  = w_shdata;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    data_mem_lane u_lane (
      .i_en  (w_be[g]),
      .i_old (w_old_b[g]),
      .i_new (w_new_b[g]),
      .o_byte(w_merged_b[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
      end
    end
  end

  // RAM keeps its contents across reset; an aborted request never reaches RESP.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= w_merged_b;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        else               w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid  = 1'b1;
        resp_err    = w_err;
        if (!w_err && !r_write) resp_rdata = w_rdword;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-level memory model.

module tb_data_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 3;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  logic [63:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nbytes(input logic [1:0] s);
    return 8 >> s;
  endfunction

  function automatic bit m_err(input logic [63:0] a, input logic [1:0] s);
    return ((a % nbytes(s)) != 0) || ((a >> 3) >= DEPTH);
  endfunction

  task automatic m_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    int idx, off;
    idx = int'(a >> 3);
    off = int'(a[2:0]);
    for (int b = 0; b < nbytes(s); b++) m_mem[idx][8*(off+b) +: 8] = d[8*b +: 8];
  endtask

  // Issue one request and wait (bounded) for its response; lat counts clock edges from
  // the accept edge to the edge that samples resp_valid high, -1 on timeout.
  task automatic do_req(input bit w, input logic [63:0] a, input logic [1:0] s,
                        input logic [63:0] d, output logic [63:0] rd, output logic e,
                        output int lat);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = d;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = {$urandom, $urandom};
    req_size = 2'($urandom); req_wdata = {$urandom, $urandom};
    lat = -1; rd = '0; e = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; rd = resp_rdata; e = resp_err; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", req_ready); end
    vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    vec++; if (resp_rdata !== 64'h0) begin errs++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    vec++; if (resp_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", resp_err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load;
    logic [63:0] rd; logic e; int lat;
    do_req(1'b1, 64'h40, 2'b00, 64'h1122334455667788, rd, e, lat);
    m_store(64'h40, 2'b00, 64'h1122334455667788); m_known[8] = 1'b1;
    vec++; if (lat !== LATENCY + 1 || e !== 1'b0 || rd !== 64'h0) begin
      errs++; $display("FAIL sd_resp lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=0", lat, e, rd, LATENCY + 1);
    end
    do_req(1'b0, 64'h40, 2'b00, 64'h0, rd, e, lat);
    vec++; if (lat !== LATENCY + 1) begin errs++; $display("FAIL ld_latency got %0d want %0d", lat, LATENCY + 1); end
    vec++; if (rd !== 64'h1122334455667788 || e !== 1'b0) begin
      errs++; $display("FAIL ld_data got %h err=%b want 1122334455667788 err=0", rd, e);
    end
    // response is a single-cycle pulse
    @(negedge clk);
    vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errs++; $display("FAIL pulse_width valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_byte_merge;
    logic [63:0] rd; logic e; int lat;
    do_req(1'b1, 64'h43, 2'b11, 64'hAB, rd, e, lat);
    m_store(64'h43, 2'b11, 64'hAB);
    do_req(1'b0, 64'h40, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== 64'h11223344AB667788 || e !== 1'b0) begin
      errs++; $display("FAIL sb_merge got %h want 11223344ab667788", rd);
    end
    do_req(1'b1, 64'h46, 2'b10, 64'hBEEF, rd, e, lat);
    m_store(64'h46, 2'b10, 64'hBEEF);
    do_req(1'b0, 64'h40, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== 64'hBEEF3344AB667788 || rd !== m_mem[8]) begin
      errs++; $display("FAIL sh_merge got %h want beef3344ab667788", rd);
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic e; int lat;
    do_req(1'b1, 64'h42, 2'b01, 64'hDEADBEEF, rd, e, lat);
    vec++; if (e !== 1'b1 || lat !== LATENCY + 1) begin errs++; $display("FAIL sw_misal err=%b lat=%0d want 1/%0d", e, lat, LATENCY + 1); end
    do_req(1'b0, 64'h40, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== m_mem[8]) begin errs++; $display("FAIL misal_nowrite got %h want %h", rd, m_mem[8]); end
    do_req(1'b0, 64'(DEPTH * 8), 2'b00, 64'h0, rd, e, lat);
    vec++; if (e !== 1'b1 || rd !== 64'h0) begin errs++; $display("FAIL ld_oor err=%b rdata=%h want 1/0", e, rd); end
    do_req(1'b0, 64'h41, 2'b10, 64'h0, rd, e, lat);
    vec++; if (e !== 1'b1 || rd !== 64'h0) begin errs++; $display("FAIL lh_misal err=%b rdata=%h want 1/0", e, rd); end
    do_req(1'b0, 64'h44, 2'b00, 64'h0, rd, e, lat);
    vec++; if (e !== 1'b1 || rd !== 64'h0) begin errs++; $display("FAIL ld_misal err=%b rdata=%h want 1/0", e, rd); end
  endtask

  task automatic test_busy;
    logic [63:0] rd; logic e; int lat; int k; bit seen; bit ready_bad;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h48; req_size = 2'b00; req_wdata = 64'hA5A5_0001_A5A5_0001;
    @(posedge clk); #1;
    // held request with different contents must wait until the responder is idle again
    req_addr = 64'h50; req_wdata = 64'h5A5A_0002_5A5A_0002;
    seen = 1'b0; ready_bad = 1'b0;
    for (k = 1; k <= 50 && !seen; k++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      if (resp_valid) seen = 1'b1;
    end
    vec++; if (ready_bad || !seen) begin errs++; $display("FAIL busy_ready ready_seen_high=%b resp_seen=%b want 0/1", ready_bad, seen); end
    @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL ready_after_resp got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (resp_valid) break; end
    m_store(64'h48, 2'b00, 64'hA5A5_0001_A5A5_0001); m_known[9] = 1'b1;
    m_store(64'h50, 2'b00, 64'h5A5A_0002_5A5A_0002); m_known[10] = 1'b1;
    do_req(1'b0, 64'h48, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== m_mem[9]) begin errs++; $display("FAIL busy_first got %h want %h", rd, m_mem[9]); end
    do_req(1'b0, 64'h50, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== m_mem[10]) begin errs++; $display("FAIL busy_second got %h want %h", rd, m_mem[10]); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd; logic e; int lat; int last, k;
    logic [63:0] d;
    @(negedge clk);
    last = -1;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'(32 + i) << 3; req_size = 2'b00; req_wdata = d;
      k = 0;
      while (!req_ready && k < 50) begin @(negedge clk); k++; end
      @(posedge clk);
      if (last >= 0) begin
        vec++; if (cyc - last !== LATENCY + 2) begin
          errs++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, cyc - last, LATENCY + 2);
        end
      end
      last = cyc;
      m_store(64'(32 + i) << 3, 2'b00, d); m_known[32 + i] = 1'b1;
      #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (resp_valid) break; end
    for (int i = 0; i < 16; i += 5) begin
      do_req(1'b0, 64'(32 + i) << 3, 2'b00, 64'h0, rd, e, lat);
      vec++; if (rd !== m_mem[32 + i] || e !== 1'b0) begin
        errs++; $display("FAIL b2b_readback[%0d] got %h want %h", i, rd, m_mem[32 + i]);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, a, d; logic e; int lat, w; logic [1:0] s; bit wr, xe;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      do_req(1'b1, 64'(i) << 3, 2'b00, d, rd, e, lat);
      m_store(64'(i) << 3, 2'b00, d); m_known[i] = 1'b1;
    end
    for (int n = 0; n < 60; n++) begin
      s = 2'($urandom); wr = 1'($urandom);
      w = $urandom_range(0, 15);
      a = (64'(w) << 3) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a + 64'(DEPTH * 8) * 64'($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) a[63] = 1'b1;
      d = {$urandom, $urandom};
      do_req(wr, a, s, d, rd, e, lat);
      xe = m_err(a, s);
      vec++;
      if (lat !== LATENCY + 1 || e !== xe) begin
        errs++; $display("FAIL rand[%0d] a=%h s=%0d w=%b lat=%0d err=%b want lat=%0d err=%b", n, a, s, wr, lat, e, LATENCY + 1, xe);
      end else if (wr || xe) begin
        if (rd !== 64'h0) begin errs++; $display("FAIL rand[%0d] rdata=%h want 0", n, rd); end
      end else if (rd !== m_mem[w]) begin
        errs++; $display("FAIL rand[%0d] ld a=%h got %h want %h", n, a, rd, m_mem[w]);
      end
      if (wr && !xe) m_store(a, s, d);
    end
  endtask

  task automatic test_reset_midop;
    logic [63:0] rd; logic e; int lat; bit bad;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h80; req_size = 2'b00; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'h0) begin
      errs++; $display("FAIL midop_reset ready=%b valid=%b err=%b rdata=%h want 1/0/0/0", req_ready, resp_valid, resp_err, resp_rdata);
    end
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_valid) bad = 1'b1; end
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (resp_valid) bad = 1'b1; end
    vec++; if (bad) begin errs++; $display("FAIL midop_no_resp got resp_valid=1 want none"); end
    do_req(1'b0, 64'h80, 2'b00, 64'h0, rd, e, lat);
    vec++; if (rd !== m_mem[16] || e !== 1'b0) begin
      errs++; $display("FAIL midop_old_value got %h want %h", rd, m_mem[16]);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
    test_reset;
    test_store_load;
    test_byte_merge;
    test_errors;
    test_busy;
    test_back_to_back;
    test_random;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
